// File: rtl/dsadd_pkg.sv
// Shared definitions for the digit-serial adder: controller states and
// the helper that sizes the digit counter.
package dsadd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; kept at one bit or more so NDIG==1 still has a counter
    function automatic int cnt_width(input int ndig);
        int w;
        w = $clog2(ndig);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational DIGIT-bit ripple-carry slice. It also exposes the carry
// into its top bit, which is needed for signed-overflow detection.
module rca_slice #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    // Ripple the carry bit by bit from ci up to the slice carry-out
    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign s     = a ^ b ^ c[DIGIT-1:0];
    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock through a
// single ripple slice with a registered carry, taking WIDTH/DIGIT cycles.
// Operands and results use valid/ready handshakes.
// Optional macro DSADD_OVF_EN adds the signed-overflow output Ovf.
module digit_serial_adder
    import dsadd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef DSADD_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             last_dig;
`ifdef DSADD_OVF_EN
    logic             dig_cmsb;
`else
    logic             dig_cmsb_unused;
`endif

    assign dig_a     = opa[cnt*DIGIT +: DIGIT];
    assign dig_b     = opb[cnt*DIGIT +: DIGIT];
    assign last_dig  = (cnt == LAST);
    assign In_ready  = (state == IDLE);
    assign Out_valid = (state == DONE);

    rca_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a     (dig_a),
        .b     (dig_b),
        .ci    (carry),
        .s     (dig_s),
        .co    (dig_co),
`ifdef DSADD_OVF_EN
        .c_msb (dig_cmsb)
`else
        .c_msb (dig_cmsb_unused)
`endif
    );

    // Controller state register
    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, step digits in RUN, wait for consumer in DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (In_valid)  state_nxt = RUN;
            RUN:     if (last_dig)  state_nxt = DONE;
            DONE:    if (Out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands (B pre-inverted for subtract), then one digit per RUN cycle
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_valid) begin
                        opa   <= A;
                        opb   <= Sub ? ~B : B;
                        carry <= Cin ^ Sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    Sum[cnt*DIGIT +: DIGIT] <= dig_s;
                    carry                   <= dig_co;
                    if (last_dig) begin
                        Cout <= dig_co;
                        cnt  <= '0;
                    end else begin
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DSADD_OVF_EN
    // Signed overflow from the top digit: carry into MSB differs from carry out of MSB
    always_ff @(posedge Clk) begin
        if (!Reset_n)                      Ovf <= 1'b0;
        else if (state == RUN && last_dig) Ovf <= dig_cmsb ^ dig_co;
    end
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Testbench for digit_serial_adder (WIDTH=32, DIGIT=8). Directed cases
// followed by random operations, each compared against an arithmetic
// reference model. Build with DSADD_OVF_EN defined to also check Ovf.
module tb_digit_serial_adder;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             Clk;
    logic             Reset_n;
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             Out_valid;
    logic             Out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef DSADD_OVF_EN
    logic             Ovf;
`endif

    int passCount  = 0;
    int failCount  = 0;
    int totalCount = 0;

    digit_serial_adder #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Sum       (Sum),
        .Cout      (Cout)
`ifdef DSADD_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    // Free-running clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Step past the next rising edge; sampling and driving both happen here
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Add is A+B+Cin; subtract is
    // A-B-Cin (Cin as borrow-in), biased by 2^32 so bit 32 means "no borrow".
    function automatic logic [32:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input logic sub);
        longint r;
        if (sub) r = 64'h1_0000_0000 + longint'(a) - longint'(b) - longint'(cin);
        else     r = longint'(a) + longint'(b) + longint'(cin);
        return r[32:0];
    endfunction

    // Reference signed overflow: true signed result outside the 32-bit range
    function automatic logic refOvf(input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) r = sa - sb - longint'(cin);
        else     r = sa + sb + longint'(cin);
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // One full transaction: accept, latency check, result check, optional backpressure, drain
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub, input int hold);
        logic [32:0] exp;
        exp = refResult(a, b, cin, sub);
        checkOutput({tag, ".ready"}, 32'(In_ready), 32'd1);
        In_valid = 1'b1;
        A        = a;
        B        = b;
        Cin      = cin;
        Sub      = sub;
        tick();
        In_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        Cin      = 1'($urandom);
        Sub      = 1'($urandom);
        checkOutput({tag, ".busy"}, 32'(In_ready), 32'd0);
        for (int i = 1; i < NDIG; i++) begin
            tick();
            checkOutput({tag, ".early"}, 32'(Out_valid), 32'd0);
        end
        tick();
        checkOutput({tag, ".valid"}, 32'(Out_valid), 32'd1);
        checkOutput({tag, ".sum"},   Sum,            exp[31:0]);
        checkOutput({tag, ".cout"},  32'(Cout),      32'(exp[32]));
`ifdef DSADD_OVF_EN
        checkOutput({tag, ".ovf"},   32'(Ovf),       32'(refOvf(a, b, cin, sub)));
`endif
        for (int h = 0; h < hold; h++) begin
            In_valid = (h == 0);
            A        = ~a;
            tick();
            In_valid = 1'b0;
            checkOutput({tag, ".holdv"}, 32'(Out_valid), 32'd1);
            checkOutput({tag, ".holdr"}, 32'(In_ready),  32'd0);
            checkOutput({tag, ".holds"}, Sum,            exp[31:0]);
        end
        Out_ready = 1'b1;
        tick();
        Out_ready = 1'b0;
        checkOutput({tag, ".drainv"}, 32'(Out_valid), 32'd0);
        checkOutput({tag, ".drainr"}, 32'(In_ready),  32'd1);
    endtask

    // Directed then random sequence
    initial begin
        Reset_n   = 1'b0;
        In_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        Sub       = 1'b0;
        Out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst.ready", 32'(In_ready),  32'd1);
        checkOutput("rst.valid", 32'(Out_valid), 32'd0);
        checkOutput("rst.sum",   Sum,            32'd0);
        checkOutput("rst.cout",  32'(Cout),      32'd0);
        Reset_n = 1'b1;
        tick();

        applyStimulus("add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
        applyStimulus("ripple",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
        applyStimulus("sub_5_7",   32'd5,         32'd7,         1'b0, 1'b1, 0);
        applyStimulus("sub_7_5",   32'd7,         32'd5,         1'b0, 1'b1, 0);
        applyStimulus("backpress", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 6);

        // Reset after two RUN edges discards the operation
        In_valid = 1'b1;
        A        = 32'hDEAD_BEEF;
        B        = 32'h1111_1111;
        Cin      = 1'b0;
        Sub      = 1'b0;
        tick();
        In_valid = 1'b0;
        tick();
        tick();
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        checkOutput("midrst.ready", 32'(In_ready),  32'd1);
        checkOutput("midrst.valid", 32'(Out_valid), 32'd0);
        checkOutput("midrst.sum",   Sum,            32'd0);
        checkOutput("midrst.cout",  32'(Cout),      32'd0);
        for (int i = 0; i < NDIG + 1; i++) begin
            tick();
            checkOutput("midrst.idle", 32'(Out_valid), 32'd0);
        end
        applyStimulus("after_rst", 32'd1, 32'd1, 1'b0, 1'b0, 0);

        applyStimulus("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        applyStimulus("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
        applyStimulus("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            applyStimulus("rand", $urandom, $urandom, 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
